// File: rtl/rom_loader_smd.sv
// Converts the ioctl download stream into big-endian Genesis ROM words on a toggle-handshake
// write port: plain images are byte swapped, SMD images are header stripped and de-interleaved.
module rom_loader_smd #(
  parameter int unsigned HDR_BYTES = 512,
  parameter int unsigned BLK_LOG2  = 14
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        smd,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_data,
  output logic        ioctl_wait,
  output logic [24:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        wr_req,
  input  logic        wr_ack,
  output logic [24:0] rom_size
);
  localparam int unsigned AW        = 25;
  localparam int unsigned DW        = 16;
  localparam int unsigned IW        = BLK_LOG2 - 2;
  localparam int unsigned BUF_WORDS = 1 << IW;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WAIT, S_RD, S_WR0, S_WAIT0, S_WR1, S_WAIT1
  } state_t;

  state_t        state_q, state_d;
  logic          dl_q;
  logic          mode_q, mode_d;
  logic          wait_q, wait_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] size_q, size_d;
  logic [AW-1:0] seg_q, seg_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] buf_q;
  logic [DW-1:0] half_buf [BUF_WORDS];

  logic          dl_rise, accept, in_hdr, half_hi, buf_we, buf_re;
  logic [AW-1:0] g, seg, next_size;
  logic [IW-1:0] buf_idx;

  // Decode the file offset: g is the offset past the header, seg the ROM address of write 0
  always_comb begin
    in_hdr    = ioctl_addr < AW'(HDR_BYTES);
    g         = in_hdr ? '0 : ioctl_addr - AW'(HDR_BYTES);
    half_hi   = g[BLK_LOG2-1];
    buf_idx   = g[BLK_LOG2-2:1];
    seg       = {g[AW-1:BLK_LOG2], {BLK_LOG2{1'b0}}} + AW'({g[BLK_LOG2-2:0], 1'b0});
    dl_rise   = ioctl_download & ~dl_q;
    accept    = ioctl_download & ioctl_wr & (state_q == S_IDLE);
    buf_we    = accept & mode_q & ~in_hdr & ~half_hi;
    buf_re    = accept & mode_q & ~in_hdr & half_hi;
    next_size = addr_q + AW'(2);
  end

  // Odd-byte half-block buffer; the read result is held until the next even-half word
  always_ff @(posedge clk_sys) begin
    if (buf_we) half_buf[buf_idx] <= ioctl_data;
    if (buf_re) buf_q <= half_buf[buf_idx];
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    wait_d  = wait_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    hold_d  = hold_q;
    seg_d   = seg_q;

    case (state_q)
      S_IDLE: begin
        wait_d = 1'b0;
        if (accept) begin
          hold_d = ioctl_data;
          if (!mode_q) begin
            addr_d  = ioctl_addr;
            data_d  = {ioctl_data[7:0], ioctl_data[15:8]};
            wait_d  = 1'b1;
            state_d = S_WR;
          end else if (!in_hdr) begin
            wait_d = 1'b1;
            if (half_hi) begin
              seg_d   = seg;
              state_d = S_RD;
            end
          end
        end
      end
      S_WR, S_WR0, S_WR1: begin
        req_d = ~req_q;
        if (next_size > size_q) size_d = next_size;
        state_d = (state_q == S_WR) ? S_WAIT : (state_q == S_WR0) ? S_WAIT0 : S_WAIT1;
      end
      S_WAIT, S_WAIT1: begin
        if (wr_ack == req_q) begin
          wait_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        addr_d  = seg_q;
        data_d  = {hold_q[7:0], buf_q[7:0]};
        state_d = S_WR0;
      end
      S_WAIT0: begin
        if (wr_ack == req_q) begin
          addr_d  = seg_q + AW'(2);
          data_d  = {hold_q[15:8], buf_q[15:8]};
          state_d = S_WR1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new download realigns the handshake and restarts size tracking
    if (dl_rise) begin
      mode_d  = smd;
      req_d   = wr_ack;
      size_d  = '0;
      wait_d  = 1'b0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
      dl_q    <= 1'b0;
      mode_q  <= 1'b0;
      wait_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      hold_q  <= '0;
      seg_q   <= '0;
    end else begin
      state_q <= state_d;
      dl_q    <= ioctl_download;
      mode_q  <= mode_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      hold_q  <= hold_d;
      seg_q   <= seg_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign wr_req     = req_q;
  assign rom_size   = size_q;

endmodule

// File: tb/tb_rom_loader_smd.sv
// Scoreboard bench for rom_loader_smd: a file-byte model predicts ROM writes, a monitor checks
// them as wr_req toggles, and a randomized downstream responder acks them.
module tb_rom_loader_smd;
  localparam int HDR  = 512;
  localparam int BLK  = 16384;
  localparam int HALF = 8192;

  typedef struct packed { logic [24:0] a; logic [15:0] d; } wr_t;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        smd = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_data = '0;
  logic        wr_ack = 1'b0;
  logic        ioctl_wait;
  logic [24:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_req;
  logic [24:0] rom_size;

  rom_loader_smd dut (
    .clk_sys(clk_sys), .reset(reset), .smd(smd), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ioctl_wait(ioctl_wait), .wr_addr(wr_addr), .wr_data(wr_data), .wr_req(wr_req),
    .wr_ack(wr_ack), .rom_size(rom_size)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0, n_writes = 0, ack_cyc = 0, fixed_lat = -1;
  bit mon_en = 0, resp_en = 0;

  wr_t         exp_q[$];
  logic [7:0]  file_b [int];
  logic [24:0] model_size;
  bit          model_smd;

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int a, input logic [15:0] d);
    wr_t e;
    e.a = 25'(a);
    e.d = d;
    exp_q.push_back(e);
    if (25'(a + 2) > model_size) model_size = 25'(a + 2);
  endtask

  // Reference: plain = byte swap; SMD block = first half holds odd ROM bytes, second half even
  task automatic model_word(input int a, input logic [15:0] d, output int kind);
    if (!model_smd) begin
      push_exp(a, {d[7:0], d[15:8]});
      kind = 2;
    end else if (a < HDR) begin
      kind = 0;
    end else begin
      int g, off, base, i;
      g    = a - HDR;
      off  = g % BLK;
      base = g - off;
      if (off < HALF) begin
        file_b[a]     = d[7:0];
        file_b[a + 1] = d[15:8];
        kind = 1;
      end else begin
        i = off - HALF;
        push_exp(base + 2 * i,     {d[7:0],  file_b[a - HALF]});
        push_exp(base + 2 * i + 2, {d[15:8], file_b[a - HALF + 1]});
        kind = 2;
      end
    end
  endtask

  task automatic pulse_wr(input int a, input logic [15:0] d);
    @(posedge clk_sys); #1;
    ioctl_addr = 25'(a);
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr   = 1'b0;
  endtask

  task automatic send_word(input int a, input logic [15:0] d);
    int kind, t;
    bit ok;
    model_word(a, d, kind);
    pulse_wr(a, d);
    if (kind == 0) begin
      ok = !ioctl_wait;
      @(posedge clk_sys); #1;
      ok &= !ioctl_wait;
      check("hdr_no_wait", ok, ioctl_wait, 0);
    end else if (kind == 1) begin
      ok = ioctl_wait;
      @(posedge clk_sys); #1;
      ok &= !ioctl_wait;
      check("odd_wait_pulse", ok, ioctl_wait, 0);
    end else begin
      check("wait_set", ioctl_wait == 1'b1, ioctl_wait, 1);
      t = 0;
      while (ioctl_wait && t < 400) begin
        @(posedge clk_sys); #1;
        t++;
      end
      if (ioctl_wait) check("wait_timeout", 1'b0, t, 400);
      else            check("wait_drop_after_ack", (cyc - ack_cyc) == 1, cyc - ack_cyc, 1);
    end
  endtask

  task automatic start_dl(input bit s);
    mon_en  = 0;
    resp_en = 0;
    @(posedge clk_sys); #1;
    smd = s;
    ioctl_download = 1'b1;
    model_smd  = s;
    model_size = '0;
    file_b.delete();
    @(posedge clk_sys); #1;
    check("realign_req", wr_req == wr_ack, wr_req, wr_ack);
    check("size_clear", rom_size == 0, rom_size, 0);
    mon_en  = 1;
    resp_en = 1;
  endtask

  task automatic end_dl();
    repeat (2) @(posedge clk_sys);
    #1;
    check("rom_size", rom_size == model_size, rom_size, model_size);
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  // Downstream responder: random ack latency, checks hold-off and payload stability
  logic [24:0] r_a;
  logic [15:0] r_d;
  bit          r_ok, r_abort;
  int          r_lat;
  initial begin
    forever begin
      @(negedge clk_sys);
      if (resp_en && !reset && wr_req !== wr_ack) begin
        r_a = wr_addr;
        r_d = wr_data;
        r_ok = 1;
        r_abort = 0;
        r_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        for (int i = 0; i < r_lat; i++) begin
          @(negedge clk_sys);
          if (!resp_en || reset) begin
            r_abort = 1;
            break;
          end
          if (wr_addr !== r_a || wr_data !== r_d || ioctl_wait !== 1'b1) r_ok = 0;
        end
        if (!r_abort) begin
          check("hold_stable", r_ok, {wr_addr, wr_data, ioctl_wait}, {r_a, r_d, 1'b1});
          wr_ack  = wr_req;
          ack_cyc = cyc;
        end
      end
    end
  end

  // Monitor: each new request (wr_req departing from wr_ack) is one issued write
  initial begin
    bit pq, p;
    wr_t e;
    pq = 0;
    forever begin
      @(posedge clk_sys); #1;
      p = (wr_req !== wr_ack);
      if (mon_en && p && !pq) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1'b0, {wr_addr, wr_data}, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", wr_addr == e.a, wr_addr, e.a);
          check("wr_data", wr_data == e.d, wr_data, e.d);
        end
      end
      pq = p;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int offs[8];
    int w0, t, base;
    logic rq;

    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_wait", ioctl_wait == 1'b0, ioctl_wait, 0);
    check("rst_outputs", {wr_req, wr_addr, wr_data, rom_size} == '0,
          {wr_req, wr_addr, wr_data, rom_size}, 0);
    reset = 1'b0;

    // Plain image: directed word, long ack latency, then random words
    start_dl(0);
    send_word(0, 16'h3412);
    check("plain_size_2", rom_size == 25'd2, rom_size, 2);
    fixed_lat = 20;
    send_word(32'h100, 16'hA55A);
    fixed_lat = -1;
    repeat (20) send_word(2 * int'($urandom_range(0, 32'hFFFFF)), 16'($urandom));
    end_dl();

    // SMD header only: nothing written
    start_dl(1);
    for (int a = 0; a < HDR; a += 2) send_word(a, 16'($urandom));
    end_dl();
    check("hdr_size_0", rom_size == 0, rom_size, 0);

    // SMD block 0 directed
    start_dl(1);
    send_word(32'h200, 16'hBBAA);
    send_word(32'h2200, 16'hDDCC);
    end_dl();
    check("blk0_size_4", rom_size == 25'd4, rom_size, 4);

    // SMD block 1 directed, then random sparse blocks with a truncated tail
    start_dl(1);
    send_word(32'h4200, 16'h2211);
    send_word(32'h6200, 16'h4433);
    for (int b = 0; b < 4; b++) begin
      base = HDR + b * BLK;
      for (int k = 0; k < 8; k++) offs[k] = 2 * int'($urandom_range(0, 4095));
      for (int k = 0; k < 8; k++) send_word(base + offs[k], 16'($urandom));
      if (b < 3)
        for (int k = 0; k < 6; k++) send_word(base + HALF + offs[k], 16'($urandom));
    end
    end_dl();

    // Reset while the first write of an even-half word is outstanding
    start_dl(1);
    send_word(32'h300, 16'h5678);
    push_exp(32'h200, 16'hBC78);
    fixed_lat = 30;
    w0 = n_writes;
    pulse_wr(32'h2300, 16'h9ABC);
    t = 0;
    while (n_writes == w0 && t < 50) begin
      @(posedge clk_sys); #1;
      t++;
    end
    check("rst_write0_seen", n_writes != w0, n_writes, w0 + 1);
    repeat (5) @(posedge clk_sys);
    #1;
    check("rst_wait0_held", ioctl_wait == 1'b1, ioctl_wait, 1);
    mon_en  = 0;
    resp_en = 0;
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    fixed_lat = -1;
    check("rst_mid_wait", ioctl_wait == 1'b0, ioctl_wait, 0);
    check("rst_mid_req", wr_req == 1'b0, wr_req, 0);
    rq = wr_req;
    repeat (20) @(posedge clk_sys);
    #1;
    check("rst_no_toggle", wr_req == rq && ioctl_wait == 1'b0, {wr_req, ioctl_wait}, {rq, 1'b0});
    start_dl(1);
    send_word(32'h300, 16'h1357);
    send_word(32'h2300, 16'h2468);
    end_dl();

    check("queue_empty", exp_q.size() == 0, exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rom_loader_smd.md
Name: rom_loader_smd

Overview:
- Sits between the HPS ioctl download stream (16-bit wide) and the DDR3 ROM write port.
- Converts the downloaded file into big-endian Genesis ROM words and issues toggle-handshake writes downstream. Upstream is held off with ioctl_wait.
- Two input formats:
  - plain BIN/GEN/MD: byte swap only;
  - SMD: 512-byte header stripped, then each 16 KB block de-interleaved.
- Also reports the loaded ROM size for mapper and SRAM logic.

Parameters:
- HDR_BYTES, 512, SMD header length dropped from the start of the file.
- BLK_LOG2, 14, log2 of SMD block size in bytes. The half-block is 2^(BLK_LOG2-1) bytes.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- smd  in  1  format select, sampled on rising ioctl_download: 1 = SMD, 0 = plain
- ioctl_download  in  1  download active
- ioctl_wr  in  1  single-cycle strobe, one input word valid
- ioctl_addr  in  25  file byte offset of the word (always even)
- ioctl_data  in  16  [7:0] = byte at offset ioctl_addr, [15:8] = byte at offset ioctl_addr+1
- ioctl_wait  out  1  upstream hold-off
- wr_addr  out  25  ROM byte address of the output word (even)
- wr_data  out  16  [15:8] = even-address ROM byte, [7:0] = odd-address ROM byte
- wr_req  out  1  toggles once per output write
- wr_ack  in  1  downstream toggles to match wr_req when the write completes
- rom_size  out  25  highest written wr_addr + 2

Behaviour:
- Reset values: ioctl_wait=0, wr_req=0, wr_addr=0, wr_data=0, rom_size=0, state IDLE, mode latch=0.
- On the rising edge of ioctl_download:
  - mode <= smd;
  - wr_req <= wr_ack;
  - rom_size <= 0;
  - state IDLE.
- ioctl_wait:
  - set in the cycle after ioctl_wr is accepted;
  - held until every output write for that input word has been acked;
  - cleared the same cycle wr_ack == wr_req is observed in the final wait state.
- ioctl_wr arriving while state != IDLE is ignored; the protocol forbids it.
- Write issue: wr_addr and wr_data are stable before wr_req toggles and must not change until wr_ack == wr_req.
- rom_size <= max(rom_size, wr_addr+2) at each issue.
- Plain mode, per ioctl_wr:
  - one write: wr_addr=ioctl_addr, wr_data={ioctl_data[7:0], ioctl_data[15:8]}.
  - States: IDLE -> WR -> WAIT -> IDLE.
- SMD mode: let g = ioctl_addr - HDR_BYTES, b = g[24:BLK_LOG2], h = g[BLK_LOG2-1], o = g[BLK_LOG2-2:0].
  - ioctl_addr < HDR_BYTES: word dropped, no write, ioctl_wait not asserted.
  - h=0 (odd-byte half): write ioctl_data into the 4K x 16 half-buffer at o>>1. No downstream write. ioctl_wait pulses exactly one cycle.
  - h=1 (even-byte half):
    - read buffer at o>>1 (1-cycle BRAM latency, state RD) giving q;
    - write 0: wr_addr = (b<<BLK_LOG2) + 2*o, wr_data = {ioctl_data[7:0], q[7:0]};
    - write 1: wr_addr = that + 2, wr_data = {ioctl_data[15:8], q[15:8]}.
  - States: IDLE -> RD -> WR0 -> WAIT0 -> WR1 -> WAIT1 -> IDLE.
- Data widths: input data latched on ioctl_wr into a 16-bit hold register. Address arithmetic is 25-bit unsigned; header subtraction is never performed for ioctl_addr < HDR_BYTES.
- Truncated SMD file:
  - a trailing partial first half produces no writes;
  - a partial second half writes only the words received.
- ioctl_download falling mid-sequence: the in-flight sequence completes, then IDLE.
- reset mid-sequence:
  - state returns to IDLE and ioctl_wait to 0;
  - wr_req is not toggled further;
  - any pending downstream ack is ignored and realigned on the next download start.

Test Plan:
- Plain: download start with wr_ack=0, ioctl_wr addr=0x000000 data=0x3412 -> one wr_req toggle with wr_addr=0, wr_data=0x1234; ioctl_wait high until ack; rom_size=2.
- Ack latency: downstream acks after 20 cycles -> ioctl_wait stays 1 for all 20 cycles; wr_addr/wr_data stable throughout; ioctl_wait=0 the cycle after the ack.
- SMD header: smd=1, words at 0..510 -> zero wr_req toggles and ioctl_wait never asserted; rom_size=0.
- SMD block 0:
  - stimulus: file 0x200 data=0xBBAA, then file 0x2200 data=0xDDCC;
  - required: exactly two writes, (0x0000, 0xCCAA) then (0x0002, 0xDDBB); rom_size=4.
- SMD block 1: file offset 0x4200 odd data=0x2211, 0x6200 even data=0x4433 -> writes (0x4000, 0x3311), (0x4002, 0x4422).
- Reset mid-sequence: assert reset while in WAIT0 -> ioctl_wait=0, state IDLE. The next download start realigns wr_req to wr_ack, and the first write of the new download is correct.
